// File: rtl/ps2_direction_decoder.sv
// PS/2 Set 2 scan-code stream -> held direction levels for two players (arrows and W/A/S/D).
// Define LAST_KEY_WINS_EN to make each player's outputs one-hot of the most recently made held key.
module ps2_direction_decoder #(
    parameter int PREFIX_TIMEOUT = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic [2:0] dir0_code,
    output logic [2:0] dir1_code,
    output logic       seq_error
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    localparam logic [7:0]       BYTE_EXT = 8'hE0;
    localparam logic [7:0]       BYTE_BRK = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    // Direction masks use bit 0 = up, 1 = right, 2 = down, 3 = left for both players.
    function automatic logic [3:0] map_ext(input logic [7:0] b);
        case (b)
            8'h75:   return 4'b0001;
            8'h74:   return 4'b0010;
            8'h72:   return 4'b0100;
            8'h6B:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] map_std(input logic [7:0] b);
        case (b)
            8'h1D:   return 4'b0001;
            8'h23:   return 4'b0010;
            8'h1B:   return 4'b0100;
            8'h1C:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] dir_code(input logic [3:0] s);
        case (s)
            4'b0001: return 3'd1;
            4'b0010: return 3'd2;
            4'b0100: return 3'd3;
            4'b1000: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] lowest_code(input logic [3:0] s);
        if (s[0]) return 3'd1;
        if (s[1]) return 3'd2;
        if (s[2]) return 3'd3;
        if (s[3]) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] code_onehot(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // A newly pressed key wins; releasing the winner falls back to the lowest held direction.
    function automatic logic [2:0] next_win(input logic [2:0] win, input logic [3:0] held_old,
                                            input logic [3:0] held_new, input logic [3:0] make);
        logic [3:0] fresh;
        fresh = make & ~held_old;
        if (fresh != 4'b0000) return lowest_code(fresh);
        if ((win != 3'd0) && ((code_onehot(win) & held_new) == 4'b0000)) return lowest_code(held_new);
        return win;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       held0_p0;
    logic [3:0]       held1_p0;
    logic [3:0]       held0_nxt;
    logic [3:0]       held1_nxt;
    logic [3:0]       mask0;
    logic [3:0]       mask1;
    logic             is_ext;
    logic             is_brk;
    logic             err_nxt;
    logic [3:0]       sig0;
    logic [3:0]       sig1;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        held0_nxt = held0_p0;
        held1_nxt = held1_p0;
        err_nxt   = 1'b0;
        mask0     = 4'b0000;
        mask1     = 4'b0000;
        is_ext    = (state_q == EXT) || (state_q == EXT_BRK);
        is_brk    = (state_q == BRK) || (state_q == EXT_BRK);
        if (ps2_key_pressed) begin
            cnt_nxt = '0;
            if (ps2_out == BYTE_EXT) begin
                state_nxt = is_brk ? EXT_BRK : EXT;
            end else if (ps2_out == BYTE_BRK) begin
                state_nxt = is_ext ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
                if (is_ext) mask0 = map_ext(ps2_out);
                else        mask1 = map_std(ps2_out);
                if (is_brk) begin
                    held0_nxt = held0_p0 & ~mask0;
                    held1_nxt = held1_p0 & ~mask1;
                end else begin
                    held0_nxt = held0_p0 | mask0;
                    held1_nxt = held1_p0 | mask1;
                end
            end
        end else if (state_q != IDLE) begin
            // Stale prefix: drop the sequence, keep the held keys.
            if (cnt_q == CNT_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                err_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    // Stage p0: decoder state, held keys, error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held0_p0  <= 4'b0000;
            held1_p0  <= 4'b0000;
            seq_error <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            held0_p0  <= held0_nxt;
            held1_p0  <= held1_nxt;
            seq_error <= err_nxt;
        end
    end

`ifdef LAST_KEY_WINS_EN
    logic [2:0] win0_p0;
    logic [2:0] win1_p0;
    logic [2:0] win0_nxt;
    logic [2:0] win1_nxt;

    always_comb begin
        win0_nxt = next_win(win0_p0, held0_p0, held0_nxt, is_brk ? 4'b0000 : mask0);
        win1_nxt = next_win(win1_p0, held1_p0, held1_nxt, is_brk ? 4'b0000 : mask1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win0_p0 <= 3'd0;
            win1_p0 <= 3'd0;
        end else begin
            win0_p0 <= win0_nxt;
            win1_p0 <= win1_nxt;
        end
    end

    assign sig0 = code_onehot(win0_p0);
    assign sig1 = code_onehot(win1_p0);
`else
    assign sig0 = held0_p0;
    assign sig1 = held1_p0;
`endif

    // Stage p1: direction codes from the visible levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir0_code <= 3'd0;
            dir1_code <= 3'd0;
        end else begin
            dir0_code <= dir_code(sig0);
            dir1_code <= dir_code(sig1);
        end
    end

    assign upSig     = sig0[0];
    assign rightSig  = sig0[1];
    assign downSig   = sig0[2];
    assign leftSig   = sig0[3];
    assign upSig2    = sig1[0];
    assign rightSig2 = sig1[1];
    assign downSig2  = sig1[2];
    assign leftSig2  = sig1[3];

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: directed test-plan steps plus random byte streams against a key-table model.
// Honours LAST_KEY_WINS_EN when the design is built with it.
module tb_ps2_direction_decoder;
    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key = 1'b0;
    logic [7:0] ps2_out = 8'h00;
    logic       upSig, rightSig, downSig, leftSig;
    logic       upSig2, rightSig2, downSig2, leftSig2;
    logic [2:0] dir0_code, dir1_code;
    logic       seq_error;

    always #5 clock = ~clock;

    ps2_direction_decoder #(.PREFIX_TIMEOUT(T), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .ps2_key_pressed(key), .ps2_out(ps2_out),
        .upSig(upSig), .rightSig(rightSig), .downSig(downSig), .leftSig(leftSig),
        .upSig2(upSig2), .rightSig2(rightSig2), .downSig2(downSig2), .leftSig2(leftSig2),
        .dir0_code(dir0_code), .dir1_code(dir1_code), .seq_error(seq_error)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which keys are down, whether a prefix is pending and for how long.
    logic [3:0] held0, held1;
    int         win0, win1;
    bit         pend, m_ext, m_brk;
    int         idle_cnt;
    logic [3:0] exp_sig0, exp_sig1;
    logic [2:0] exp_code0, exp_code1;
    logic       exp_err;

    function automatic int ext_dir(input logic [7:0] b);
        case (b)
            8'h75: return 0;
            8'h74: return 1;
            8'h72: return 2;
            8'h6B: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int std_dir(input logic [7:0] b);
        case (b)
            8'h1D: return 0;
            8'h23: return 1;
            8'h1B: return 2;
            8'h1C: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input logic [3:0] s);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < 4; i++) if (s[i]) begin n++; idx = i + 1; end
        return (n == 1) ? 3'(idx) : 3'd0;
    endfunction

    function automatic logic [3:0] shown(input logic [3:0] h, input int w);
`ifdef LAST_KEY_WINS_EN
        if (w == 0) return 4'b0000;
        return 4'(1 << (w - 1));
`else
        if (w < 0) return 4'b0000;
        return h;
`endif
    endfunction

    task automatic apply_key(inout logic [3:0] h, inout int w, input int d, input bit brk);
        if (!brk) begin
            if (!h[d]) w = d + 1;
            h[d] = 1'b1;
        end else begin
            h[d] = 1'b0;
            if (w == d + 1) begin
                w = 0;
                for (int i = 3; i >= 0; i--) if (h[i]) w = i + 1;
            end
        end
    endtask

    task automatic m_clear();
        held0 = 4'b0; held1 = 4'b0; win0 = 0; win1 = 0;
        pend = 0; m_ext = 0; m_brk = 0; idle_cnt = 0;
        exp_sig0 = 4'b0; exp_sig1 = 4'b0; exp_code0 = 3'd0; exp_code1 = 3'd0; exp_err = 1'b0;
    endtask

    // Advance the model across one clock edge with the given strobe/byte.
    task automatic step(input bit k, input logic [7:0] b);
        int d;
        exp_code0 = code_of(exp_sig0);
        exp_code1 = code_of(exp_sig1);
        exp_err   = 1'b0;
        if (k) begin
            idle_cnt = 0;
            if (b == 8'hE0) begin
                pend = 1; m_ext = 1;
            end else if (b == 8'hF0) begin
                pend = 1; m_brk = 1;
            end else begin
                if (m_ext) begin
                    d = ext_dir(b);
                    if (d >= 0) apply_key(held0, win0, d, m_brk);
                end else begin
                    d = std_dir(b);
                    if (d >= 0) apply_key(held1, win1, d, m_brk);
                end
                pend = 0; m_ext = 0; m_brk = 0;
            end
        end else if (pend) begin
            idle_cnt++;
            if (idle_cnt == T) begin
                exp_err = 1'b1;
                pend = 0; m_ext = 0; m_brk = 0; idle_cnt = 0;
            end
        end
        exp_sig0 = shown(held0, win0);
        exp_sig1 = shown(held1, win1);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("sig0", {4'b0, leftSig, downSig, rightSig, upSig}, {4'b0, exp_sig0});
        chk("sig1", {4'b0, leftSig2, downSig2, rightSig2, upSig2}, {4'b0, exp_sig1});
        chk("dir0_code", {5'b0, dir0_code}, {5'b0, exp_code0});
        chk("dir1_code", {5'b0, dir1_code}, {5'b0, exp_code1});
        chk("seq_error", {7'b0, seq_error}, {7'b0, exp_err});
    endtask

    // One clock: check outputs of the previous edge, then drive the next edge's inputs.
    task automatic cycle(input bit k, input logic [7:0] b);
        @(negedge clock);
        check_all();
        key = k;
        ps2_out = b;
        step(k, b);
    endtask

    task automatic do_reset();
        @(negedge clock);
        check_all();
        reset = 1'b0;
        key = 1'b0;
        ps2_out = 8'h00;
        m_clear();
        #1 check_all();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b1;
        step(1'b0, 8'h00);
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B, 8'h1D,
                              8'h23, 8'h1B, 8'h1C, 8'hAA, 8'hFA, 8'h12, 8'hE1};
    int npulse;
    int gap;

    initial begin
        m_clear();
        #1 check_all();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b1;
        step(1'b0, 8'h00);

        // Up arrow make then break.
        cycle(1, 8'hE0); cycle(1, 8'h75); cycle(0, 8'h00);
        chk("up_make", {7'b0, upSig}, 8'd1);
        cycle(0, 8'h00);
        chk("up_code", {5'b0, dir0_code}, 8'd1);
        cycle(1, 8'hE0); cycle(1, 8'hF0); cycle(1, 8'h75); cycle(0, 8'h00); cycle(0, 8'h00);
        chk("up_break", {7'b0, upSig}, 8'd0);
        chk("up_break_code", {5'b0, dir0_code}, 8'd0);

        // W + A held together.
        cycle(1, 8'h1D); cycle(1, 8'h1C); cycle(0, 8'h00); cycle(0, 8'h00);
`ifdef LAST_KEY_WINS_EN
        chk("wa_sig", {6'b0, upSig2, leftSig2}, 8'b01);
        chk("wa_code", {5'b0, dir1_code}, 8'd4);
`else
        chk("wa_sig", {6'b0, upSig2, leftSig2}, 8'b11);
        chk("wa_code", {5'b0, dir1_code}, 8'd0);
`endif
        cycle(1, 8'hF0); cycle(1, 8'h1C); cycle(0, 8'h00); cycle(0, 8'h00);
        chk("w_only_code", {5'b0, dir1_code}, 8'd1);
        cycle(1, 8'hF0); cycle(1, 8'h1D); cycle(0, 8'h00);

        // Keypad code without prefix, extended W.
        cycle(1, 8'h75); cycle(0, 8'h00); cycle(0, 8'h00);
        chk("keypad_p0", {4'b0, leftSig, downSig, rightSig, upSig}, 8'd0);
        cycle(1, 8'hE0); cycle(1, 8'h1D); cycle(0, 8'h00); cycle(0, 8'h00);
        chk("ext_w_p1", {4'b0, leftSig2, downSig2, rightSig2, upSig2}, 8'd0);

        // Prefix timeout.
        cycle(1, 8'hE0);
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 8'h00);
            npulse += int'(seq_error);
        end
        chk("timeout_pulses", 8'(npulse), 8'd1);
        cycle(1, 8'h74); cycle(0, 8'h00);
        chk("after_timeout", {7'b0, rightSig}, 8'd0);

        // Reset in the middle of a break sequence.
        cycle(1, 8'hE0); cycle(1, 8'h74); cycle(0, 8'h00);
        chk("right_held", {7'b0, rightSig}, 8'd1);
        cycle(1, 8'hE0); cycle(1, 8'hF0);
        do_reset();
        cycle(1, 8'h74); cycle(0, 8'h00); cycle(0, 8'h00);
        chk("trailing_74", {7'b0, rightSig}, 8'd0);
        chk("trailing_code", {5'b0, dir0_code}, 8'd0);

        // Typematic right arrow, strobes back-to-back.
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'hE0);
            if (i >= 1) chk("typematic_sig", {7'b0, rightSig}, 8'd1);
            if (i >= 2) chk("typematic_code", {5'b0, dir0_code}, 8'd2);
            cycle(1, 8'h74);
            if (i >= 1) chk("typematic_sig", {7'b0, rightSig}, 8'd1);
            if (i >= 1) chk("typematic_code", {5'b0, dir0_code}, 8'd2);
        end
        cycle(0, 8'h00);

        // Random byte streams with idle gaps, some long enough to time out a prefix.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                cycle(1, pool[$urandom_range(0, 13)]);
            end else begin
                gap = $urandom_range(1, 20);
                repeat (gap) cycle(0, 8'h00);
            end
            if (i == 250) do_reset();
        end
        cycle(0, 8'h00);
        cycle(0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Converts the PS/2 keyboard byte stream (Set 2 scan codes) into held-key direction levels for both players.
- Feeds the processor wrapper's direction inputs: upSig/rightSig/downSig/leftSig for player 0 and upSig2/rightSig2/downSig2/leftSig2 for player 1.
- Player 0 uses the arrow keys (E0-extended codes). Player 1 uses W/A/S/D.
- Handles make, break and extended-prefix sequences, and times out stale prefixes.

Parameters:
- PREFIX_TIMEOUT, 1000000, clock cycles allowed between a prefix byte (E0/F0) and the next byte before the decoder abandons the sequence.
- CNT_W, 20, width of the prefix timeout counter. Must hold PREFIX_TIMEOUT.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_key_pressed  input  1  one-cycle strobe; ps2_out holds a valid byte while it is high.
- ps2_out  input  8  received scan-code byte.
- upSig, rightSig, downSig, leftSig  output  1 each  player 0 held levels (up, right, down, left arrows).
- upSig2, rightSig2, downSig2, leftSig2  output  1 each  player 1 held levels (W, D, S, A).
- dir0_code, dir1_code  output  3 each  direction codes: 0 none, 1 up, 2 right, 3 down, 4 left.
- seq_error  output  1  one-cycle pulse when a prefix times out.

Behaviour:
- Reset (reset=0, asynchronous):
  - all signal outputs 0, both codes 0, seq_error 0;
  - FSM in IDLE; timeout counter 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on an edge with ps2_key_pressed=1, unless stated otherwise.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code; stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte is an extended make; -> IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT_BRK; any other byte is a break; -> IDLE.
  - EXT_BRK: E0/F0 -> stay; any other byte is an extended break; -> IDLE.
- Key mapping:
  - Extended: 75 = up0, 74 = right0, 72 = down0, 6B = left0.
  - Non-extended: 1D = up1 (W), 23 = right1 (D), 1B = down1 (S), 1C = left1 (A).
  - Make sets the held bit; break clears it.
  - Unmapped codes (including AA, FA, FE, E1) change no held bit.
  - A non-extended 75/74/72/6B (keypad) does not affect player 0.
  - An extended 1D/23/1B/1C does not affect player 1.
- Latency:
  - Held bits and signal outputs are registered and change on the same edge that samples the final byte; they are visible the following cycle.
  - Codes are registered from the held bits one edge later (2-cycle byte-to-code latency).
- Code rule: exactly one held direction for a player gives that code; zero or more than one gives 0.
- Repeated make (typematic) of a held key leaves state unchanged, with no glitch.
- Prefix timeout:
  - The counter runs only in EXT, BRK and EXT_BRK; it clears on every accepted byte and on entry to IDLE.
  - Reaching PREFIX_TIMEOUT-1 with no strobe: return to IDLE, pulse seq_error for 1 cycle, held bits unchanged.
  - A strobe on the same edge as the timeout takes priority: the byte is decoded and seq_error stays 0.
- Reset mid-sequence releases all keys. A break that arrives afterwards has no effect.
- Strobes on consecutive cycles are each processed; the strobe is not required to drop between bytes.

Optional Feature:
- LAST_KEY_WINS_EN defined:
  - Each player tracks the most recently made direction that is still held.
  - The signal outputs become one-hot of that direction, so the wrapper always sees a single direction.
  - On release of the winning key, the output falls back to the lowest-numbered remaining held direction (up > right > down > left priority), or none.
  - Codes follow the one-hot outputs.
- LAST_KEY_WINS_EN not defined: signal outputs are the raw held bits, and codes follow the code rule.

Test Plan:
- Reset, then bytes E0,75 -> upSig=1 after the 75 edge; dir0_code=1 one cycle later. Then E0,F0,75 -> upSig=0, dir0_code=0.
- Bytes 1D then 1C (W+A held) -> upSig2=1, leftSig2=1, dir1_code=0. With LAST_KEY_WINS_EN: leftSig2=1, upSig2=0, dir1_code=4. Then F0,1C -> dir1_code=1.
- Byte 75 without prefix -> all player 0 outputs stay 0. Bytes E0,1D -> player 1 outputs stay 0.
- E0 then idle for PREFIX_TIMEOUT=16 (override) cycles -> seq_error pulses once, FSM back in IDLE. A following 74 (non-extended) leaves rightSig=0.
- Hold right arrow (E0,74), assert reset=0 for 2 cycles mid-stream after an E0,F0 -> all outputs 0. A trailing 74 has no effect.
- Typematic E0,74 sent five times back-to-back with strobes on consecutive cycles -> rightSig held at 1 throughout, dir0_code=2 steady.
